// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage pipelined magnitude comparator with a sideband tag.
// Stage 1 pre-transforms operands by mode and registers per-chunk gt/eq flags;
// stage 2 resolves the chunks MSB-first into one-hot gt/eq/lt output registers.
// Valid/ready backpressure, no skid buffer: in_ready is combinational from out_ready.

// Per-chunk unsigned compare slice.
module fp_compare_chunk #(
    parameter int CW = 7
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic          gt,
    output logic          eq
);
    assign gt = (a > b);
    assign eq = (a == b);
endmodule

module fp_compare_pipe #(
    parameter int WIDTH = 28,
    parameter int CHUNK = 7,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;

    localparam logic [1:0] MODE_UNS = 2'b00;
    localparam logic [1:0] MODE_SGN = 2'b01;
    localparam logic [1:0] MODE_SM  = 2'b10;

    logic s1_valid, s2_valid, s1_adv, s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Reserved mode folds onto unsigned so stage 2 only sees three modes.
    logic [1:0]       mode_n;
    logic [WIDTH-1:0] ta, tb;
    logic             both_zero;

    assign mode_n = (in_mode == 2'b11) ? MODE_UNS : in_mode;

    // Operand pre-transform: bias the sign for two's complement, strip it for sign-magnitude.
    always_comb begin
        ta = in_a;
        tb = in_b;
        if (mode_n == MODE_SGN) begin
            ta[WIDTH-1] = ~in_a[WIDTH-1];
            tb[WIDTH-1] = ~in_b[WIDTH-1];
        end else if (mode_n == MODE_SM) begin
            ta[WIDTH-1] = 1'b0;
            tb[WIDTH-1] = 1'b0;
        end
    end

    assign both_zero = (in_a[WIDTH-2:0] == '0) && (in_b[WIDTH-2:0] == '0);

    // Top chunk may be partial: zero-extend both operands the same way.
    logic [PW-1:0]     pa, pb;
    logic [NCHUNK-1:0] cgt, ceq;

    assign pa = PW'(ta);
    assign pb = PW'(tb);

    for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
        fp_compare_chunk #(.CW(CHUNK)) u_chunk (
            .a  (pa[k*CHUNK +: CHUNK]),
            .b  (pb[k*CHUNK +: CHUNK]),
            .gt (cgt[k]),
            .eq (ceq[k])
        );
    end

    logic [NCHUNK-1:0] s1_cgt, s1_ceq;
    logic [1:0]        s1_mode;
    logic              s1_sa, s1_sb, s1_bz;
    logic [TAG_W-1:0]  s1_tag;

    // Stage 1 register: capture chunk flags, signs and sideband on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cgt  <= cgt;
                s1_ceq  <= ceq;
                s1_mode <= mode_n;
                s1_sa   <= in_a[WIDTH-1];
                s1_sb   <= in_b[WIDTH-1];
                s1_bz   <= both_zero;
                s1_tag  <= in_tag;
            end
        end
    end

    logic ugt, ueq, r_gt, r_eq, r_lt;

    // Stage 2 resolve: the most significant differing chunk decides; then apply sign rules.
    always_comb begin
        ugt = 1'b0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (!s1_ceq[k]) ugt = s1_cgt[k];
        end
        ueq  = &s1_ceq;
        r_gt = ugt;
        r_eq = ueq;
        r_lt = !ugt && !ueq;
        if (s1_mode == MODE_SM) begin
            if (s1_bz) begin
                r_gt = 1'b0;
                r_eq = 1'b1;
                r_lt = 1'b0;
            end else if (s1_sa != s1_sb) begin
                r_gt = !s1_sa;
                r_eq = 1'b0;
                r_lt = s1_sa;
            end else if (s1_sa) begin
                r_gt = !ugt && !ueq;
                r_lt = ugt;
            end
        end
    end

    // Stage 2 / output register: load a new result only when the consumer side can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_gt   <= 1'b0;
            out_eq   <= 1'b0;
            out_lt   <= 1'b0;
            out_tag  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_gt  <= r_gt;
                out_eq  <= r_eq;
                out_lt  <= r_lt;
                out_tag <= s1_tag;
            end
        end
    end
endmodule
